// File: rtl/fp_spike_accumulator_pkg.sv
// fp_spike_accumulator_pkg: shared FSM encodings and FP32 constants
package fp_spike_accumulator_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_ADD   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;
  localparam logic [31:0] FP_ZERO = 32'h0000_0000;
endpackage

// File: rtl/Addition_Subtraction.sv
// Addition_Subtraction: combinational FP32 add/sub, truncating, returns zero with Exception on inf/nan inputs
module Addition_Subtraction (
  input  logic [31:0] a_operand,
  input  logic [31:0] b_operand,
  input  logic        AddBar_Sub,
  output logic        Exception,
  output logic [31:0] result
);
  logic        b_sign, swap, sx, sy;
  logic [30:0] x, y;
  logic [7:0]  ex, ey, diff;
  logic [23:0] mx, my, ms, d;
  logic [24:0] sum;
  logic [4:0]  lz;
  logic [22:0] norm;
  logic [31:0] raw;
  always_comb begin
    b_sign = b_operand[31] ^ AddBar_Sub;
    swap = b_operand[30:0] > a_operand[30:0];
    sx = swap ? b_sign : a_operand[31];
    sy = swap ? a_operand[31] : b_sign;
    x = swap ? b_operand[30:0] : a_operand[30:0];
    y = swap ? a_operand[30:0] : b_operand[30:0];
    ex = (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
    ey = (y[30:23] == 8'd0) ? 8'd1 : y[30:23];
    mx = {|x[30:23], x[22:0]};
    my = {|y[30:23], y[22:0]};
    diff = ex - ey;
    ms = (diff > 8'd23) ? 24'd0 : my >> diff;
    sum = {1'b0, mx} + {1'b0, ms};
    d = mx - ms;
    lz = 5'd0;
    for (int i = 0; i < 24; i++)
      if (d[i]) lz = 5'(23 - i);
    norm = d[22:0] << lz;
    raw = (sx == sy) ?
            (sum[24] ? ((ex == 8'd254) ? {sx, 8'hFF, 23'd0} : {sx, ex + 8'd1, sum[23:1]})
                     : {sx, sum[23] ? ex : 8'd0, sum[22:0]})
          : ((d == 24'd0 || {3'b0, lz} >= ex) ? 32'd0 : {sx, ex - {3'b0, lz}, norm});
    Exception = (&a_operand[30:23]) | (&b_operand[30:23]);
    result = Exception ? 32'd0 : raw;
  end
endmodule

// File: rtl/fp_spike_accumulator.sv
// fp_spike_accumulator: streams FP32 weights through the add/sub unit into a membrane accumulator
module fp_spike_accumulator
  import fp_spike_accumulator_pkg::*;
#(
  parameter logic [31:0] INIT_VALUE = FP_ZERO,
  parameter int          MAX_BEATS  = 16,
  parameter int          CNT_W      = 5
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_sub,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             out_exception,
  output logic [CNT_W-1:0] out_beats
);
  state_t           state, state_nxt;
  logic [31:0]      acc, op_reg, add_res;
  logic             sub_reg, last_reg, sticky, add_exc, in_fire, out_fire;
  logic [CNT_W-1:0] count;
  Addition_Subtraction u_addsub (
    .a_operand  (acc),
    .b_operand  (op_reg),
    .AddBar_Sub (sub_reg),
    .Exception  (add_exc),
    .result     (add_res)
  );
  always_comb begin
    in_ready = (state == ST_IDLE) || (state == ST_ACCUM);
    out_valid = state == ST_DONE;
    out_data = acc;
    out_exception = sticky;
    out_beats = count;
    in_fire = in_valid && in_ready;
    out_fire = out_valid && out_ready;
    state_nxt = in_fire ? ST_ADD
              : (state == ST_ADD) ? (last_reg ? ST_DONE : ST_ACCUM)
              : out_fire ? ST_IDLE
              : state;
  end
  always_ff @(posedge CLK) begin
    if (!RESET_N) state <= ST_IDLE;
    else state <= state_nxt;
  end
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      acc <= INIT_VALUE;
      op_reg <= 32'd0;
      sub_reg <= 1'b0;
      last_reg <= 1'b0;
      sticky <= 1'b0;
      count <= '0;
    end else begin
      if (in_fire) begin
        op_reg <= in_data;
        sub_reg <= in_sub;
        last_reg <= in_last || (count == CNT_W'(MAX_BEATS - 1));
        count <= count + 1'b1;
      end
      if (state == ST_ADD) begin
        acc <= add_res;
        sticky <= sticky | add_exc;
      end
      if (out_fire) begin
        acc <= INIT_VALUE;
        sticky <= 1'b0;
        count <= '0;
      end
    end
  end
endmodule

// File: tb/tb_fp_spike_accumulator.sv
// tb_fp_spike_accumulator: directed-vector self-checking bench for the spike accumulator
module tb_fp_spike_accumulator;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        in_valid = 1'b0, in_sub = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [31:0] in_data = 32'd0;
  logic        in_ready, out_valid, out_exception;
  logic [31:0] out_data;
  logic [2:0]  out_beats;
  int          checks = 0, failures = 0, cyc = 0, hs = 0;
  fp_spike_accumulator #(.INIT_VALUE(32'h0), .MAX_BEATS(4), .CNT_W(3)) dut (
    .CLK           (clk),
    .RESET_N       (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .in_sub        (in_sub),
    .in_last       (in_last),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_exception (out_exception),
    .out_beats     (out_beats)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask
  task automatic beat(input logic [31:0] d, input logic s, input logic l);
    int n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("beat_ready_timeout", 32'(in_ready), 32'd1);
    hs = cyc;
    in_valid = 1'b1;
    in_data = d;
    in_sub = s;
    in_last = l;
    @(negedge clk);
    in_valid = 1'b0;
    in_last = 1'b0;
    in_sub = 1'b0;
    in_data = 32'hDEAD_BEEF;
  endtask
  task automatic wait_done();
    int n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("done_reached", 32'(out_valid), 32'd1);
  endtask
  task automatic take(input string tag, input logic [31:0] d, input logic e, input logic [2:0] b);
    chk({tag, "_data"}, out_data, d);
    chk({tag, "_exc"}, 32'(out_exception), 32'(e));
    chk({tag, "_beats"}, 32'(out_beats), 32'(b));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    chk({tag, "_ready_back"}, 32'(in_ready), 32'd1);
  endtask
  initial begin
    int first_hs;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_out_exc", 32'(out_exception), 32'd0);
    chk("rst_out_beats", 32'(out_beats), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    beat(32'h3F80_0000, 1'b0, 1'b0);
    first_hs = hs;
    chk("add_busy_ready", 32'(in_ready), 32'd0);
    beat(32'h4000_0000, 1'b0, 1'b1);
    wait_done();
    chk("t1_latency", 32'(cyc - first_hs), 32'd4);
    take("t1", 32'h4040_0000, 1'b0, 3'd2);
    beat(32'h3F80_0000, 1'b0, 1'b0);
    beat(32'h4000_0000, 1'b0, 1'b0);
    beat(32'h3F00_0000, 1'b1, 1'b1);
    wait_done();
    take("t2", 32'h4020_0000, 1'b0, 3'd3);
    beat(32'h7F80_0000, 1'b0, 1'b0);
    beat(32'h3F80_0000, 1'b0, 1'b1);
    wait_done();
    take("t3", 32'h3F80_0000, 1'b1, 3'd2);
    beat(32'h3F80_0000, 1'b0, 1'b1);
    wait_done();
    take("t3_next", 32'h3F80_0000, 1'b0, 3'd1);
    for (int i = 0; i < 4; i++) beat(32'h3F80_0000, 1'b0, 1'b0);
    wait_done();
    in_valid = 1'b1;
    in_data = 32'h3F80_0000;
    for (int i = 0; i < 10; i++) begin
      chk("hold_stable", {27'd0, in_ready, out_valid, out_beats},
          {27'd0, 1'b0, 1'b1, 3'd4});
      chk("hold_data", out_data, 32'h4080_0000);
      @(negedge clk);
    end
    in_valid = 1'b0;
    take("t4", 32'h4080_0000, 1'b0, 3'd4);
    chk("t5_acc_init", out_data, 32'h0);
    chk("t5_count_init", 32'(out_beats), 32'd0);
    beat(32'h3F80_0000, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_mid_in_ready", 32'(in_ready), 32'd1);
    chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_data", out_data, 32'h0);
    chk("rst_mid_beats", 32'(out_beats), 32'd0);
    chk("rst_mid_exc", 32'(out_exception), 32'd0);
    beat(32'h4000_0000, 1'b0, 1'b1);
    wait_done();
    take("t6", 32'h4000_0000, 1'b0, 3'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
